// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported 64-bit memory between instruction fetch (IF) and
// load/store (MEM). Each access is a req/ack handshake with the memory. The
// response is a one-cycle done pulse carrying the captured read data.
// Data accesses win over fetches. A fairness counter forces a fetch grant once
// FAIR_MAX data grants have been made back-to-back while a fetch was waiting.
// An access that sees no mem_ack for TIMEOUT cycles is aborted:
// done and bus_err pulse together, and the read data is zero.
module mem_port_arbiter #(
   parameter int unsigned FAIR_MAX = 4,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [63:0] dm_addr,
   input  logic [63:0] dm_wdata,
   output logic [63:0] dm_rdata,
   output logic        dm_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack,
   output logic        bus_err,
   output logic        stall_if,
   output logic        stall_mem
);

   localparam int unsigned   SW       = $clog2(FAIR_MAX + 1);
   localparam logic [SW-1:0] FAIR_LIM = SW'(FAIR_MAX);
   localparam logic [SW-1:0] SW_ONE   = {{(SW-1){1'b0}}, 1'b1};
   localparam logic [SW-1:0] SW_ZERO  = {SW{1'b0}};
   // Abort fires on the cycle whose count would reach TIMEOUT, so mem_req
   // has been high for exactly TIMEOUT cycles when it drops.
   localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      IF_ACC = 3'd1,
      DM_ACC = 3'd2,
      IF_RSP = 3'd3,
      DM_RSP = 3'd4
   } state_t;

   state_t        state_r;
   logic [SW-1:0] starve_cnt_r;
   logic [7:0]    tmo_cnt_r;

   logic          dm_win_s;
   logic [SW-1:0] starve_next_s;
   logic [31:0]   fetch_word_s;
   logic          tmo_hit_s;

   // Stall requests go straight back to the pipeline hazard logic
   assign stall_if  = if_req & ~if_done;
   assign stall_mem = dm_req & ~dm_done;

   // Arbitration decision, fairness update, fetch word select and timeout hit
   always_comb begin
      dm_win_s      = 1'b0;
      starve_next_s = starve_cnt_r;
      fetch_word_s  = 32'd0;
      tmo_hit_s     = 1'b0;

      if (dm_req && (!if_req || (starve_cnt_r < FAIR_LIM))) begin
         dm_win_s = 1'b1;
      end else begin
         dm_win_s = 1'b0;
      end

      // A data grant with a waiting fetch counts toward starvation;
      // a data grant with no fetch waiting resets the count.
      if (!if_req) begin
         starve_next_s = SW_ZERO;
      end else if (starve_cnt_r == FAIR_LIM) begin
         starve_next_s = starve_cnt_r;
      end else begin
         starve_next_s = starve_cnt_r + SW_ONE;
      end

      // The latched fetch address picks the 32-bit half of the memory word
      if (mem_addr[2]) begin
         fetch_word_s = mem_rdata[63:32];
      end else begin
         fetch_word_s = mem_rdata[31:0];
      end

      if (tmo_cnt_r == TMO_LAST) begin
         tmo_hit_s = 1'b1;
      end else begin
         tmo_hit_s = 1'b0;
      end
   end

   // Access FSM: arbitration, memory handshake, response pulses and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 64'd0;
         mem_wdata    <= 64'd0;
         if_done      <= 1'b0;
         dm_done      <= 1'b0;
         bus_err      <= 1'b0;
         if_rdata     <= 32'd0;
         dm_rdata     <= 64'd0;
         starve_cnt_r <= SW_ZERO;
         tmo_cnt_r    <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if_done <= 1'b0;
               dm_done <= 1'b0;
               bus_err <= 1'b0;
               if (dm_win_s) begin
                  state_r      <= DM_ACC;
                  mem_req      <= 1'b1;
                  mem_we       <= dm_we;
                  mem_addr     <= dm_addr;
                  mem_wdata    <= dm_wdata;
                  tmo_cnt_r    <= 8'd0;
                  starve_cnt_r <= starve_next_s;
               end else if (if_req) begin
                  state_r      <= IF_ACC;
                  mem_req      <= 1'b1;
                  mem_we       <= 1'b0;
                  mem_addr     <= if_addr;
                  mem_wdata    <= 64'd0;
                  tmo_cnt_r    <= 8'd0;
                  starve_cnt_r <= SW_ZERO;
               end else begin
                  state_r <= IDLE;
               end
            end

            IF_ACC: begin
               if (mem_ack) begin
                  state_r  <= IF_RSP;
                  mem_req  <= 1'b0;
                  if_done  <= 1'b1;
                  if_rdata <= fetch_word_s;
               end else if (tmo_hit_s) begin
                  state_r   <= IF_RSP;
                  mem_req   <= 1'b0;
                  if_done   <= 1'b1;
                  bus_err   <= 1'b1;
                  if_rdata  <= 32'd0;
                  tmo_cnt_r <= tmo_cnt_r + 8'd1;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 8'd1;
               end
            end

            DM_ACC: begin
               if (mem_ack) begin
                  state_r  <= DM_RSP;
                  mem_req  <= 1'b0;
                  dm_done  <= 1'b1;
                  dm_rdata <= mem_rdata;
               end else if (tmo_hit_s) begin
                  state_r   <= DM_RSP;
                  mem_req   <= 1'b0;
                  dm_done   <= 1'b1;
                  bus_err   <= 1'b1;
                  dm_rdata  <= 64'd0;
                  tmo_cnt_r <= tmo_cnt_r + 8'd1;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 8'd1;
               end
            end

            // Response cycles ignore requests; the requester still holds req here
            IF_RSP: begin
               state_r <= IDLE;
               if_done <= 1'b0;
               bus_err <= 1'b0;
            end

            DM_RSP: begin
               state_r <= IDLE;
               dm_done <= 1'b0;
               bus_err <= 1'b0;
            end

            default: begin
               state_r <= IDLE;
               mem_req <= 1'b0;
               if_done <= 1'b0;
               dm_done <= 1'b0;
               bus_err <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed vector table, hand-written corner sequences (collision, starvation,
// timeout, reset mid-access), then random fetch/data traffic.
// The random traffic is checked against an address-derived memory image and
// the grant-fairness rule.
module tb_mem_port_arbiter;

   logic        clk, reset;
   logic        if_req, if_done;
   logic [63:0] if_addr;
   logic [31:0] if_rdata;
   logic        dm_req, dm_we, dm_done;
   logic [63:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        bus_err, stall_if, stall_mem;

   int total = 0;
   int bad   = 0;

   // Memory responder controls: mode 0 answers, 1 never answers, 2 acks unconditionally
   int          mem_mode   = 0;
   int          mem_lat    = 0;
   bit          rand_lat   = 1'b0;
   bit          fixed_en   = 1'b0;
   logic [63:0] fixed_data = 64'd0;
   logic [63:0] last_addr  = 64'd0;
   logic [63:0] last_wdata = 64'd0;
   logic        last_we    = 1'b0;
   bit          if_fin     = 1'b0;
   bit          dm_fin     = 1'b0;

   typedef struct {
      logic        is_dm;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          lat;
      logic [63:0] mdata;
      logic [63:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .bus_err(bus_err), .stall_if(stall_if), .stall_mem(stall_mem)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   // Memory image: every address reads back a value derived from the address
   function automatic logic [63:0] mem_func(input logic [63:0] a);
      return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Memory responder, driven just after each rising edge
   initial begin
      int wait_cnt;
      int cur_lat;
      bit acked;
      mem_ack = 1'b0; mem_rdata = 64'd0; wait_cnt = 0; cur_lat = 0; acked = 1'b0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (mem_mode == 2) begin
            mem_ack   = 1'b1;
            mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
         end else if (!mem_req) begin
            wait_cnt = 0;
            acked    = 1'b0;
         end else if (!acked) begin
            if (wait_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
            if (mem_mode == 0 && wait_cnt >= cur_lat) begin
               mem_ack    = 1'b1;
               mem_rdata  = fixed_en ? fixed_data : mem_func(mem_addr);
               last_addr  = mem_addr;
               last_we    = mem_we;
               last_wdata = mem_wdata;
               acked      = 1'b1;
            end
            wait_cnt++;
         end
      end
   end

   task automatic run_vec(input int idx, input vec_t v);
      string t;
      t = $sformatf("vec%0d", idx);
      mem_mode = 0; rand_lat = 1'b0; mem_lat = v.lat; fixed_en = 1'b1; fixed_data = v.mdata;
      @(posedge clk); #1;
      if (v.is_dm) begin
         dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      @(negedge clk);
      chk({t, "_stall"}, v.is_dm ? stall_mem : stall_if, 64'd1);
      chk({t, "_req_c0"}, mem_req, 64'd0);
      for (int c = 1; c <= v.lat + 1; c++) begin
         @(negedge clk);
         chk({t, "_mem_req"}, mem_req, 64'd1);
         chk({t, "_mem_addr"}, mem_addr, v.addr);
         chk({t, "_mem_we"}, mem_we, v.we);
         if (v.is_dm) chk({t, "_mem_wdata"}, mem_wdata, v.wdata);
         chk({t, "_early_done"}, if_done | dm_done, 64'd0);
      end
      @(negedge clk);
      chk({t, "_req_drop"}, mem_req, 64'd0);
      chk({t, "_done"}, v.is_dm ? dm_done : if_done, 64'd1);
      chk({t, "_bus_err"}, bus_err, 64'd0);
      if (!v.is_dm) chk({t, "_if_rdata"}, if_rdata, v.exp_rdata);
      else if (!v.we) chk({t, "_dm_rdata"}, dm_rdata, v.exp_rdata);
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0;
      @(negedge clk);
      chk({t, "_done_pulse"}, if_done | dm_done, 64'd0);
   endtask

   task automatic test_collision();
      bit seen_first, got_if, got_dm, stall_bad, d_if, d_dm;
      int order, dm_pos, if_pos;
      logic [63:0] first_addr, exp;
      logic [31:0] if_word;
      mem_mode = 0; fixed_en = 1'b0; rand_lat = 1'b0; mem_lat = 0;
      seen_first = 0; got_if = 0; got_dm = 0; stall_bad = 0;
      order = 0; dm_pos = -1; if_pos = -1; first_addr = 64'd0; if_word = 32'd0;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 64'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h2000;
      for (int c = 0; c < 30 && !got_if; c++) begin
         @(negedge clk);
         if (mem_req && !seen_first) begin seen_first = 1; first_addr = mem_addr; end
         if (!got_dm && !stall_if) stall_bad = 1;
         d_dm = dm_done; d_if = if_done;
         if (dm_done) begin got_dm = 1; dm_pos = order; order++; end
         if (if_done) begin got_if = 1; if_pos = order; order++; if_word = if_rdata; end
         @(posedge clk); #1;
         if (d_dm) dm_req = 1'b0;
         if (d_if) if_req = 1'b0;
      end
      exp = mem_func(64'h40);
      chk("coll_first_addr", first_addr, 64'h2000);
      chk("coll_dm_first", dm_pos, 64'd0);
      chk("coll_if_second", if_pos, 64'd1);
      chk("coll_stall_if", stall_bad, 64'd0);
      chk("coll_if_rdata", if_word, {32'd0, exp[31:0]});
      if_req = 1'b0; dm_req = 1'b0;
   endtask

   task automatic test_starve();
      logic [5:0] seq;
      int ng;
      bit stop, prev_mr, d_if, d_dm;
      mem_mode = 0; fixed_en = 1'b0; rand_lat = 1'b0; mem_lat = 0;
      seq = 6'd0; ng = 0; stop = 0; prev_mr = 0;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 64'h80; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h3000;
      for (int c = 0; c < 120 && !stop; c++) begin
         @(negedge clk);
         if (mem_req && !prev_mr && ng < 6) begin
            seq[ng] = (mem_addr == 64'h80);
            ng++;
         end
         prev_mr = mem_req; d_if = if_done; d_dm = dm_done;
         @(posedge clk); #1;
         if (d_if) if_req = 1'b0;
         if (d_dm && ng >= 6) begin dm_req = 1'b0; stop = 1; end
      end
      chk("starve_grant_count", ng, 64'd6);
      chk("starve_order", seq, 64'b01_0000);
      if_req = 1'b0; dm_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_timeout();
      int cnt;
      bit done_seen;
      cnt = 0; done_seen = 0;
      mem_mode = 1; fixed_en = 1'b0;
      @(posedge clk); #1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h5000;
      for (int c = 0; c < 400 && !done_seen; c++) begin
         @(negedge clk);
         if (mem_req) cnt++;
         else if (cnt > 0) begin
            done_seen = 1;
            chk("tmo_req_cycles", cnt, 64'd255);
            chk("tmo_dm_done", dm_done, 64'd1);
            chk("tmo_bus_err", bus_err, 64'd1);
            chk("tmo_dm_rdata", dm_rdata, 64'd0);
         end
      end
      chk("tmo_seen", done_seen, 64'd1);
      @(posedge clk); #1;
      dm_req = 1'b0; mem_mode = 0;
      @(negedge clk);
      chk("tmo_err_pulse", bus_err | dm_done, 64'd0);
   endtask

   task automatic test_reset_mid();
      mem_mode = 1;
      @(posedge clk); #1;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h6000; dm_wdata = 64'h1234_5678;
      repeat (3) @(negedge clk);
      chk("rmid_in_access", mem_req, 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("rmid_mem_req", mem_req, 64'd0);
      chk("rmid_mem_we", mem_we, 64'd0);
      chk("rmid_mem_addr", mem_addr, 64'd0);
      chk("rmid_mem_wdata", mem_wdata, 64'd0);
      chk("rmid_dones", {bus_err, if_done, dm_done}, 64'd0);
      chk("rmid_if_rdata", if_rdata, 64'd0);
      chk("rmid_dm_rdata", dm_rdata, 64'd0);
      dm_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #2;
      mem_mode = 2;
      @(posedge clk); #2;
      mem_mode = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rmid_stale_ack", {mem_req, bus_err, if_done, dm_done}, 64'd0);
      end
   endtask

   task automatic if_driver(input int n);
      logic [63:0] a, e;
      bit seen;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         a = 64'($urandom_range(0, 65535)) & 64'hFFFC;
         e = mem_func(a);
         if_req = 1'b1; if_addr = a; seen = 0;
         for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (if_done) seen = 1;
         end
         chk("rnd_if_done", seen, 64'd1);
         if (seen) begin
            chk("rnd_if_rdata", if_rdata, a[2] ? {32'd0, e[63:32]} : {32'd0, e[31:0]});
            chk("rnd_if_addr", last_addr, a);
            chk("rnd_if_we", last_we, 64'd0);
            chk("rnd_if_err", bus_err, 64'd0);
         end
         @(posedge clk); #1;
         if_req = 1'b0;
      end
      if_fin = 1'b1;
   endtask

   task automatic dm_driver(input int n);
      logic [63:0] a, wd;
      logic w;
      bit seen;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         a  = 64'h8000_0000 | (64'($urandom_range(0, 4095)) << 3);
         w  = 1'($urandom_range(0, 1));
         wd = {$urandom, $urandom};
         dm_req = 1'b1; dm_addr = a; dm_we = w; dm_wdata = wd; seen = 0;
         for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (dm_done) seen = 1;
         end
         chk("rnd_dm_done", seen, 64'd1);
         if (seen) begin
            chk("rnd_dm_addr", last_addr, a);
            chk("rnd_dm_we", last_we, w);
            if (w) chk("rnd_dm_wdata", last_wdata, wd);
            else chk("rnd_dm_rdata", dm_rdata, mem_func(a));
            chk("rnd_dm_err", bus_err, 64'd0);
         end
         @(posedge clk); #1;
         dm_req = 1'b0;
      end
      dm_fin = 1'b1;
   endtask

   // Fairness rule on every grant: data wins unless 4 data grants already went
   // by with a fetch waiting; a fetch grant over pending data needs that count.
   task automatic grant_monitor();
      bit prev_if, prev_dm, prev_mr;
      int run;
      prev_if = 0; prev_dm = 0; prev_mr = 0; run = 0;
      for (int c = 0; c < 20000 && !(if_fin && dm_fin); c++) begin
         @(negedge clk);
         if (mem_req && !prev_mr) begin
            if (mem_addr[31]) begin
               chk("fair_dm_requested", prev_dm, 64'd1);
               if (prev_if) run++;
               else run = 0;
               chk("fair_dm_run_le4", (run <= 4), 64'd1);
            end else begin
               chk("fair_if_requested", prev_if, 64'd1);
               if (prev_dm) chk("fair_if_after_4", run, 64'd4);
               run = 0;
            end
         end
         prev_mr = mem_req; prev_if = if_req; prev_dm = dm_req;
      end
      chk("rnd_finished", if_fin && dm_fin, 64'd1);
   endtask

   initial begin
      vecs[0] = '{is_dm:1'b0, we:1'b0, addr:64'h104, wdata:64'd0, lat:0,
                  mdata:64'hAAAA_BBBB_0000_0013, exp_rdata:64'hAAAA_BBBB};
      vecs[1] = '{is_dm:1'b0, we:1'b0, addr:64'h100, wdata:64'd0, lat:1,
                  mdata:64'hAAAA_BBBB_0000_0013, exp_rdata:64'h0000_0013};
      vecs[2] = '{is_dm:1'b1, we:1'b0, addr:64'h2008, wdata:64'd0, lat:0,
                  mdata:64'h0123_4567_89AB_CDEF, exp_rdata:64'h0123_4567_89AB_CDEF};
      vecs[3] = '{is_dm:1'b1, we:1'b1, addr:64'h2010, wdata:64'hDEAD_BEEF, lat:2,
                  mdata:64'h5555_5555_5555_5555, exp_rdata:64'd0};
      vecs[4] = '{is_dm:1'b1, we:1'b0, addr:64'h2018, wdata:64'd0, lat:3,
                  mdata:64'hFEDC_BA98_7654_3210, exp_rdata:64'hFEDC_BA98_7654_3210};
      vecs[5] = '{is_dm:1'b0, we:1'b0, addr:64'hFFFF_FFFF_FFFF_FFFC, wdata:64'd0, lat:2,
                  mdata:64'h1111_2222_3333_4444, exp_rdata:64'h1111_2222};

      reset = 1'b1; if_req = 1'b0; if_addr = 64'd0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = 64'd0; dm_wdata = 64'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", mem_req, 64'd0);
      chk("rst_mem_we", mem_we, 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      chk("rst_pulses", {bus_err, if_done, dm_done}, 64'd0);
      chk("rst_rdata", {if_rdata, dm_rdata[31:0]} | {32'd0, dm_rdata[63:32]}, 64'd0);
      chk("rst_stalls", {stall_if, stall_mem}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      foreach (vecs[i]) run_vec(i, vecs[i]);
      test_collision();
      test_starve();
      test_timeout();
      test_reset_mid();

      mem_mode = 0; fixed_en = 1'b0; rand_lat = 1'b1;
      if_fin = 1'b0; dm_fin = 1'b0;
      @(posedge clk); #1;
      fork
         if_driver(40);
         dm_driver(60);
         grant_monitor();
      join

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
